// File: rtl/dmem_arbiter.sv
// Two-port arbiter for one single-port data memory. Round-robin tie-break,
// optional bounded lock (atomic sequences), and 1-cycle read return per requester.
module dmem_arbiter #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int LOCK_MAX   = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic                  a_lock,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [WIDTH-1:0]      a_wdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic                  b_lock,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [WIDTH-1:0]      b_wdata,
   output logic                  a_gnt,
   output logic                  b_gnt,
   output logic                  a_rvalid,
   output logic                  b_rvalid,
   output logic [WIDTH-1:0]      a_rdata,
   output logic [WIDTH-1:0]      b_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]      mem_din,
   output logic                  mem_wren,
   input  logic [WIDTH-1:0]      mem_dout,
   output logic                  lock_timeout
);

   typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

   localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

   state_t           state, state_nxt;
   logic             last, last_nxt;        // 1: B was granted last
   logic [7:0]       cnt, cnt_nxt, cnt_inc;
   logic             a_blk, b_blk, a_blk_nxt, b_blk_nxt;
   logic             to_nxt;
   logic             a_vld_p1, b_vld_p1;
   logic [WIDTH-1:0] a_rdata_p1, b_rdata_p1;

   always_comb begin
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt;
      cnt_inc   = cnt + 8'd1;
      last_nxt  = last;
      to_nxt    = 1'b0;
      // a forced-release block lasts until that side drops its lock once
      a_blk_nxt = a_blk & a_lock;
      b_blk_nxt = b_blk & b_lock;
      case (state)
         IDLE: begin
            if (a_req && (!b_req || last)) a_gnt = 1'b1;
            else if (b_req)                b_gnt = 1'b1;
            if (a_gnt && a_lock && !a_blk) begin
               state_nxt = LOCK_A;
               cnt_nxt   = 8'd0;
            end else if (b_gnt && b_lock && !b_blk) begin
               state_nxt = LOCK_B;
               cnt_nxt   = 8'd0;
            end
         end
         LOCK_A: begin
            a_gnt = a_req;
            if (!a_lock) begin
               state_nxt = IDLE;
            end else if (cnt_inc == LOCK_LIM) begin
               state_nxt = IDLE;
               cnt_nxt   = 8'd0;
               to_nxt    = 1'b1;
               a_blk_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         LOCK_B: begin
            b_gnt = b_req;
            if (!b_lock) begin
               state_nxt = IDLE;
            end else if (cnt_inc == LOCK_LIM) begin
               state_nxt = IDLE;
               cnt_nxt   = 8'd0;
               to_nxt    = 1'b1;
               b_blk_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (a_gnt) last_nxt = 1'b0;
      if (b_gnt) last_nxt = 1'b1;
      // a timed-out holder yields the next tie to the other side
      if (to_nxt) last_nxt = (state == LOCK_B);
      if (reset) begin
         a_gnt = 1'b0;
         b_gnt = 1'b0;
      end
   end

   assign mem_addr = a_gnt ? a_addr  : (b_gnt ? b_addr  : '0);
   assign mem_din  = a_gnt ? a_wdata : (b_gnt ? b_wdata : '0);
   assign mem_wren = a_gnt ? a_we    : (b_gnt ? b_we    : 1'b0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         last         <= 1'b1;
         cnt          <= 8'd0;
         a_blk        <= 1'b0;
         b_blk        <= 1'b0;
         lock_timeout <= 1'b0;
      end else begin
         state        <= state_nxt;
         last         <= last_nxt;
         cnt          <= cnt_nxt;
         a_blk        <= a_blk_nxt;
         b_blk        <= b_blk_nxt;
         lock_timeout <= to_nxt;
      end
   end

   // read return stage: data captured at the grant edge, valid for one cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_vld_p1   <= 1'b0;
         b_vld_p1   <= 1'b0;
         a_rdata_p1 <= '0;
         b_rdata_p1 <= '0;
      end else begin
         a_vld_p1 <= a_gnt & ~a_we;
         b_vld_p1 <= b_gnt & ~b_we;
         if (a_gnt && !a_we) a_rdata_p1 <= mem_dout;
         if (b_gnt && !b_we) b_rdata_p1 <= mem_dout;
      end
   end

   assign a_rvalid = a_vld_p1;
   assign b_rvalid = b_vld_p1;
   assign a_rdata  = a_rdata_p1;
   assign b_rdata  = b_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table for the named scenarios, then
// random traffic checked against an owner/age reference model with its own memory image.
module tb_dmem_arbiter;

   localparam int W  = 32;
   localparam int AW = 8;
   localparam int LM = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
   logic          b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [W-1:0]  a_wdata = '0, b_wdata = '0;
   logic          a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wren, lock_timeout;
   logic [W-1:0]  a_rdata, b_rdata, mem_din, mem_dout;
   logic [AW-1:0] mem_addr;

   logic [W-1:0]  mem [256];

   int n_run  = 0;
   int n_fail = 0;
   int cur    = 0;

   dmem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
      .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
      .a_rdata(a_rdata), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren), .mem_dout(mem_dout),
      .lock_timeout(lock_timeout)
   );

   always #5 clock = ~clock;

   assign mem_dout = mem[mem_addr];
   always @(posedge clock) if (mem_wren) mem[mem_addr] <= mem_din;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[0] <= 32'h5;
      mem[6] <= 32'hA;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL step%0d %s: got %h expected %h", cur, nm, act, exp);
      end
   endtask

   typedef struct {
      logic          rst;
      logic          ar, aw, al;
      logic [AW-1:0] aa;
      logic [W-1:0]  ad;
      logic          br, bw, bl;
      logic [AW-1:0] ba;
      logic [W-1:0]  bd;
      logic [1:0]    eg;   // {a_gnt, b_gnt}
      logic [1:0]    ev;   // {a_rvalid, b_rvalid}
      logic          eto;
      logic [W-1:0]  ead, ebd;
      logic          ewr;
   } vec_t;

   function automatic vec_t mk(input int rst, ar, aw, al, aa, ad, br, bw, bl, ba, bd,
                               eg, ev, eto, ead, ebd, ewr);
      vec_t v;
      v.rst = (rst != 0); v.ar = (ar != 0); v.aw = (aw != 0); v.al = (al != 0);
      v.aa  = 8'(aa);     v.ad = 32'(ad);
      v.br  = (br != 0);  v.bw = (bw != 0); v.bl = (bl != 0);
      v.ba  = 8'(ba);     v.bd = 32'(bd);
      v.eg  = 2'(eg);     v.ev = 2'(ev);    v.eto = (eto != 0);
      v.ead = 32'(ead);   v.ebd = 32'(ebd); v.ewr = (ewr != 0);
      return v;
   endfunction

   // reference model: who owns the memory, for how many lock cycles, and per-side state
   int           m_own;      // 0 none, 1 A, 2 B
   int           m_age;
   bit           m_lastB;
   bit           m_blk [2];
   bit           m_rv  [2];
   logic [W-1:0] m_rd  [2];
   bit           m_to;
   logic [W-1:0] rmem  [256];

   task automatic model_reset();
      m_own = 0; m_age = 0; m_lastB = 1'b1; m_to = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_blk[i] = 1'b0; m_rv[i] = 1'b0; m_rd[i] = '0;
      end
   endtask

   function automatic int pick();
      if (reset)      return 0;
      if (m_own == 1) return a_req ? 1 : 0;
      if (m_own == 2) return b_req ? 2 : 0;
      if (a_req && b_req) return m_lastB ? 1 : 2;
      if (a_req) return 1;
      if (b_req) return 2;
      return 0;
   endfunction

   task automatic model_edge(input int g);
      bit lk [2];
      if (reset) begin
         model_reset();
         return;
      end
      lk[0] = a_lock; lk[1] = b_lock;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_to = 1'b0;
      if (g == 1) begin
         if (a_we) rmem[a_addr] = a_wdata;
         else begin m_rd[0] = rmem[a_addr]; m_rv[0] = 1'b1; end
         m_lastB = 1'b0;
      end else if (g == 2) begin
         if (b_we) rmem[b_addr] = b_wdata;
         else begin m_rd[1] = rmem[b_addr]; m_rv[1] = 1'b1; end
         m_lastB = 1'b1;
      end
      if (m_own != 0) begin
         if (!lk[m_own-1]) m_own = 0;
         else begin
            m_age++;
            if (m_age == LM) begin
               m_to = 1'b1;
               m_lastB = (m_own == 2);
               m_blk[m_own-1] = 1'b1;
               m_own = 0;
            end
         end
      end else if (g != 0 && lk[g-1] && !m_blk[g-1]) begin
         m_own = g;
         m_age = 0;
      end
      for (int i = 0; i < 2; i++) if (!lk[i]) m_blk[i] = 1'b0;
   endtask

   vec_t vecs [35];

   initial begin
      int g;
      logic [AW-1:0] ea;
      logic [W-1:0]  ed;
      // rst ar aw al aa ad  br bw bl ba bd  eg ev eto ead ebd ewr
      vecs[0]  = mk(1, 1,0,0,6,0,  0,0,0,0,0,  2'b00,2'b00,0, 0,0,0);
      vecs[1]  = mk(0, 1,0,0,6,0,  0,0,0,0,0,  2'b10,2'b00,0, 0,0,0);
      vecs[2]  = mk(0, 0,0,0,0,0,  0,0,0,0,0,  2'b00,2'b10,0, 'hA,0,0);
      vecs[3]  = mk(1, 0,0,0,0,0,  0,0,0,0,0,  2'b00,2'b00,0, 0,0,0);
      vecs[4]  = mk(0, 1,0,0,0,0,  1,0,0,6,0,  2'b10,2'b00,0, 0,0,0);
      vecs[5]  = mk(0, 1,0,0,0,0,  1,0,0,6,0,  2'b01,2'b10,0, 5,0,0);
      vecs[6]  = mk(0, 1,0,0,0,0,  1,0,0,6,0,  2'b10,2'b01,0, 5,'hA,0);
      vecs[7]  = mk(0, 1,0,0,0,0,  1,0,0,6,0,  2'b01,2'b10,0, 5,'hA,0);
      vecs[8]  = mk(0, 0,0,0,0,0,  0,0,0,0,0,  2'b00,2'b01,0, 5,'hA,0);
      vecs[9]  = mk(0, 0,0,0,0,0,  1,1,0,3,'h1234, 2'b01,2'b00,0, 5,'hA,1);
      vecs[10] = mk(0, 1,0,0,3,0,  0,0,0,0,0,  2'b10,2'b00,0, 5,'hA,0);
      vecs[11] = mk(0, 0,0,0,0,0,  0,0,0,0,0,  2'b00,2'b10,0, 'h1234,'hA,0);
      vecs[12] = mk(0, 0,0,0,0,0,  1,0,0,0,0,  2'b01,2'b00,0, 'h1234,'hA,0);
      vecs[13] = mk(0, 1,0,1,6,0,  1,0,0,0,0,  2'b10,2'b01,0, 'h1234,5,0);
      vecs[14] = mk(0, 1,0,1,6,0,  1,0,0,0,0,  2'b10,2'b10,0, 'hA,5,0);
      vecs[15] = mk(0, 1,0,1,6,0,  1,0,0,0,0,  2'b10,2'b10,0, 'hA,5,0);
      vecs[16] = mk(0, 0,0,0,6,0,  1,0,0,0,0,  2'b00,2'b10,0, 'hA,5,0);
      vecs[17] = mk(0, 0,0,0,0,0,  1,0,0,0,0,  2'b01,2'b00,0, 'hA,5,0);
      vecs[18] = mk(0, 0,0,0,0,0,  0,0,0,0,0,  2'b00,2'b01,0, 'hA,5,0);
      vecs[19] = mk(0, 1,0,1,6,0,  1,0,0,0,0,  2'b10,2'b00,0, 'hA,5,0);
      vecs[20] = mk(0, 1,0,1,6,0,  1,0,0,0,0,  2'b10,2'b10,0, 'hA,5,0);
      vecs[21] = mk(0, 1,0,1,6,0,  1,0,0,0,0,  2'b10,2'b10,0, 'hA,5,0);
      vecs[22] = mk(0, 1,0,1,6,0,  1,0,0,0,0,  2'b10,2'b10,0, 'hA,5,0);
      vecs[23] = mk(0, 1,0,1,6,0,  1,0,0,0,0,  2'b10,2'b10,0, 'hA,5,0);
      vecs[24] = mk(0, 1,0,1,6,0,  1,0,0,0,0,  2'b01,2'b10,1, 'hA,5,0);
      vecs[25] = mk(0, 1,0,1,6,0,  1,0,0,0,0,  2'b10,2'b01,0, 'hA,5,0);
      vecs[26] = mk(0, 1,0,1,6,0,  1,0,0,0,0,  2'b01,2'b10,0, 'hA,5,0);
      vecs[27] = mk(0, 0,0,0,0,0,  0,0,0,0,0,  2'b00,2'b01,0, 'hA,5,0);
      vecs[28] = mk(0, 0,0,0,0,0,  1,1,1,9,'hBEEF,   2'b01,2'b00,0, 'hA,5,1);
      vecs[29] = mk(0, 1,0,0,0,0,  1,1,1,10,'hCAFE,  2'b01,2'b00,0, 'hA,5,1);
      vecs[30] = mk(1, 1,0,0,0,0,  1,1,1,10,'hDEAD,  2'b00,2'b00,0, 0,0,0);
      vecs[31] = mk(0, 1,0,0,9,0,  1,1,1,11,'h7777,  2'b10,2'b00,0, 0,0,0);
      vecs[32] = mk(0, 0,0,0,0,0,  0,0,0,0,0,  2'b00,2'b10,0, 'hBEEF,0,0);
      vecs[33] = mk(0, 1,0,0,10,0, 0,0,0,0,0,  2'b10,2'b00,0, 'hBEEF,0,0);
      vecs[34] = mk(0, 0,0,0,0,0,  0,0,0,0,0,  2'b00,2'b10,0, 'hCAFE,0,0);

      for (int i = 0; i < 35; i++) begin
         @(negedge clock);
         cur     = i;
         reset   = vecs[i].rst;
         a_req   = vecs[i].ar; a_we = vecs[i].aw; a_lock = vecs[i].al;
         a_addr  = vecs[i].aa; a_wdata = vecs[i].ad;
         b_req   = vecs[i].br; b_we = vecs[i].bw; b_lock = vecs[i].bl;
         b_addr  = vecs[i].ba; b_wdata = vecs[i].bd;
         #1;
         chk("a_gnt",        32'(a_gnt),        32'(vecs[i].eg[1]));
         chk("b_gnt",        32'(b_gnt),        32'(vecs[i].eg[0]));
         chk("a_rvalid",     32'(a_rvalid),     32'(vecs[i].ev[1]));
         chk("b_rvalid",     32'(b_rvalid),     32'(vecs[i].ev[0]));
         chk("lock_timeout", 32'(lock_timeout), 32'(vecs[i].eto));
         chk("a_rdata",      a_rdata,           vecs[i].ead);
         chk("b_rdata",      b_rdata,           vecs[i].ebd);
         chk("mem_wren",     32'(mem_wren),     32'(vecs[i].ewr));
      end

      // random traffic against the reference model, starting from a fresh reset
      @(negedge clock);
      reset = 1'b1;
      a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
      model_reset();
      for (int i = 0; i < 256; i++) rmem[i] = mem[i];
      @(posedge clock);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         cur     = 100 + i;
         reset   = ($urandom_range(0, 99) == 0);
         a_req   = ($urandom_range(0, 3) != 0);
         b_req   = ($urandom_range(0, 3) != 0);
         a_we    = ($urandom_range(0, 2) == 0);
         b_we    = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 5) == 0) a_lock = ~a_lock;
         if ($urandom_range(0, 5) == 0) b_lock = ~b_lock;
         a_addr  = 8'($urandom_range(0, 15));
         b_addr  = 8'($urandom_range(0, 15));
         a_wdata = $urandom;
         b_wdata = $urandom;
         if (reset) model_reset();
         #1;
         g  = pick();
         ea = (g == 1) ? a_addr  : (g == 2) ? b_addr  : '0;
         ed = (g == 1) ? a_wdata : (g == 2) ? b_wdata : '0;
         chk("r_a_gnt",    32'(a_gnt),        32'(g == 1));
         chk("r_b_gnt",    32'(b_gnt),        32'(g == 2));
         chk("r_mem_addr", 32'(mem_addr),     32'(ea));
         chk("r_mem_din",  mem_din,           ed);
         chk("r_mem_wren", 32'(mem_wren),     32'((g == 1 && a_we) || (g == 2 && b_we)));
         chk("r_a_rvalid", 32'(a_rvalid),     32'(m_rv[0]));
         chk("r_b_rvalid", 32'(b_rvalid),     32'(m_rv[1]));
         chk("r_a_rdata",  a_rdata,           m_rd[0]);
         chk("r_b_rdata",  b_rdata,           m_rd[1]);
         chk("r_timeout",  32'(lock_timeout), 32'(m_to));
         @(posedge clock);
         model_edge(g);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data word width.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the word-address width.
REQ-003 Parameter LOCK_MAX, default 16, SHALL set the maximum cycles a lock is held (range 1..255).
REQ-004 Port clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 Ports a_req, b_req  input  1 each  SHALL request one memory access this cycle.
REQ-007 Ports a_we, b_we  input  1 each  SHALL select write (1) or read (0).
REQ-008 Ports a_lock, b_lock  input  1 each  SHALL request exclusive ownership across cycles (atomic sequence).
REQ-009 Ports a_addr, b_addr  input  ADDR_WIDTH each  SHALL carry the word address.
REQ-010 Ports a_wdata, b_wdata  input  WIDTH each  SHALL carry the write data.
REQ-011 Ports a_gnt, b_gnt  output  1 each  SHALL indicate, combinationally and in the same cycle, that the access is performed.
REQ-012 Ports a_rvalid, b_rvalid  output  1 each  SHALL pulse one cycle after a granted read.
REQ-013 Ports a_rdata, b_rdata  output  WIDTH each  SHALL hold the last read data returned to that requester.
REQ-014 Ports mem_addr (ADDR_WIDTH), mem_din (WIDTH), mem_wren (1)  output  SHALL drive the single-port data memory.
REQ-015 Port mem_dout  input  WIDTH  SHALL be the memory's combinational read data for mem_addr.
REQ-016 Port lock_timeout  output  1  SHALL pulse one cycle when a lock is forcibly released.

Function
REQ-017 Arbiter SHALL grant at most one requester per cycle; a_gnt and b_gnt never both 1.
REQ-018 FSM states SHALL be IDLE, LOCK_A, LOCK_B.
REQ-019 IDLE: single requester SHALL be granted; both requesting -> grant the one not granted last (round-robin pointer `last`).
REQ-020 Pointer `last` SHALL update to the granted requester on every grant edge.
REQ-021 IDLE -> LOCK_x SHALL occur on the edge where x is granted with x_lock=1.
REQ-022 LOCK_x: only x SHALL be grantable (if x_req=1); the other requester's gnt SHALL be 0 regardless of its req.
REQ-023 LOCK_x -> IDLE SHALL occur on the edge of any cycle with x_lock=0; an access granted in that cycle completes normally.
REQ-024 Lock counter SHALL clear on entry to LOCK_x and increment each cycle in LOCK_x.
REQ-025 Counter reaching LOCK_MAX in LOCK_x SHALL force -> IDLE, pulse lock_timeout next cycle, and set `last`=x so the other side wins the next tie.
REQ-026 After a forced release, x_lock held high SHALL NOT re-enter LOCK_x until x deasserts x_lock for at least one cycle.
REQ-027 Mux: granted x SHALL drive mem_addr=x_addr, mem_din=x_wdata, mem_wren=x_we; no grant -> mem_addr=0, mem_din=0, mem_wren=0.
REQ-028 Granted read: x_rdata SHALL capture mem_dout at that edge; x_rvalid=1 for exactly the following cycle.
REQ-029 Granted write SHALL NOT assert x_rvalid or alter x_rdata.
REQ-030 Back-to-back grants to the same requester SHALL yield one rvalid per read, with no dropped cycles.
REQ-031 Read latency SHALL be 1 cycle from grant to rvalid; write completes at the grant edge.

Reset
REQ-032 While reset=1: state=IDLE, `last`=B (A wins first tie), counter=0, a/b_rvalid=0, a/b_rdata=0, lock_timeout=0.
REQ-033 While reset=1, a_gnt, b_gnt and mem_wren SHALL be 0 combinationally.
REQ-034 Reset asserted mid-lock SHALL abandon the lock immediately; no memory write occurs while reset is asserted.

Verification (bench memory preloaded: word 0 = 0x5, word 6 = 0xA)
REQ-035 After reset, A reads addr 6 -> a_gnt same cycle, a_rvalid next cycle, a_rdata=0x0000000A.
REQ-036 A and B both request reads continuously for 4 cycles -> grants A,B,A,B; rvalid pulses alternate accordingly.
REQ-037 B writes 0x1234 to addr 3, then A reads addr 3 next cycle -> a_rdata=0x00001234; b_rvalid stays 0.
REQ-038 A asserts lock with req for 3 cycles while B requests -> b_gnt=0 for those 3 cycles; b_gnt=1 in the cycle after A drops lock.
REQ-039 A holds lock and req for LOCK_MAX+2 cycles (LOCK_MAX=4) -> forced release after 4 lock cycles, lock_timeout pulses once, B granted next.
REQ-040 Reset asserted during LOCK_B with b_we=1 -> mem_wren=0 immediately, all outputs at reset values, A granted first after release.
